// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit scan driver with tear-free frame-boundary code updates.
// Define SCAN_BLANK_EN to insert BLANK_CYC dark cycles before each digit.
module display_scan_controller #(
    parameter int DWELL     = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [11:0] codes_in,
    output logic        selector,
    output logic        entry_Bit1,
    output logic        entry_Bit0,
    output logic [3:0]  digit_n,
    output logic        frame_done
);
    localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYC - 1);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

    state_t        state;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic [CW-1:0] cnt;
    logic [11:0]   pending;
    logic [11:0]   active;
    logic [11:0]   active_nxt;
    logic          dwell_end;
    logic          wrap;

    function automatic logic [2:0] code_of(input logic [11:0] v,
                                           input logic [1:0] k);
        logic [2:0] c;
        unique case (k)
            2'd0:    c = v[2:0];
            2'd1:    c = v[5:3];
            2'd2:    c = v[8:6];
            default: c = v[11:9];
        endcase
        return c;
    endfunction

    function automatic logic [3:0] lit(input logic [1:0] k);
        return ~(4'b0001 << k);
    endfunction

    // active only changes at the frame boundary or while idle, never mid-frame
    always_comb begin
        idx_nxt    = idx + 2'd1;
        dwell_end  = (state == SHOW) && (cnt == DW_LAST);
        wrap       = en && dwell_end && (idx == 2'd3);
        active_nxt = active;
        if (state == IDLE || wrap)
            active_nxt = load ? codes_in : pending;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            pending    <= '0;
            active     <= '0;
            digit_n    <= 4'b1111;
            selector   <= 1'b0;
            entry_Bit1 <= 1'b0;
            entry_Bit0 <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            active     <= active_nxt;
            frame_done <= 1'b0;
            if (load)
                pending <= codes_in;
            if (!en) begin
                state   <= IDLE;
                idx     <= 2'd0;
                cnt     <= '0;
                digit_n <= 4'b1111;
            end else begin
                unique case (state)
                    IDLE: begin
                        idx <= 2'd0;
                        cnt <= '0;
`ifdef SCAN_BLANK_EN
                        state <= BLANK;
`else
                        state   <= SHOW;
                        digit_n <= lit(2'd0);
                        {selector, entry_Bit1, entry_Bit0} <=
                            code_of(active_nxt, 2'd0);
`endif
                    end
`ifdef SCAN_BLANK_EN
                    BLANK: begin
                        if (cnt == BL_LAST) begin
                            cnt     <= '0;
                            state   <= SHOW;
                            digit_n <= lit(idx);
                            {selector, entry_Bit1, entry_Bit0} <=
                                code_of(active_nxt, idx);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    SHOW: begin
                        if (dwell_end) begin
                            cnt        <= '0;
                            idx        <= idx_nxt;
                            frame_done <= (idx == 2'd3);
`ifdef SCAN_BLANK_EN
                            state   <= BLANK;
                            digit_n <= 4'b1111;
`else
                            digit_n <= lit(idx_nxt);
                            {selector, entry_Bit1, entry_Bit0} <=
                                code_of(active_nxt, idx_nxt);
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (DWELL=4, BLANK_CYC=2).
// Expected dark cycles per digit follow SCAN_BLANK_EN.
module tb_display_scan_controller;
    localparam int DW = 4;
`ifdef SCAN_BLANK_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [11:0] codes_in = '0;
    logic        selector, entry_Bit1, entry_Bit0;
    logic [3:0]  digit_n;
    logic        frame_done;

    int nvec = 0;
    int nbad = 0;

    display_scan_controller #(.DWELL(4), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .codes_in   (codes_in),
        .selector   (selector),
        .entry_Bit1 (entry_Bit1),
        .entry_Bit0 (entry_Bit0),
        .digit_n    (digit_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got,
                         input logic [11:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] dig(input int k);
        logic [3:0] d;
        d = 4'b1111;
        d[k] = 1'b0;
        return d;
    endfunction

    // k: digit, code: expected decoder code, wrapped: frame_done due on
    // first cycle, ld_at: lit cycle after which load is pulsed, n_lit: lit
    // cycles to run.
    task automatic run_digit(input int k, input logic [2:0] code,
                             input bit wrapped, input int ld_at,
                             input logic [11:0] ld_val, input int n_lit);
        bit first;
        first = 1'b1;
        for (int i = 0; i < BL; i++) begin
            tick();
            load = 1'b0;
            check("dark", digit_n, 4'b1111);
            check("fd_dark", frame_done, first && wrapped);
            first = 1'b0;
        end
        for (int i = 0; i < n_lit; i++) begin
            tick();
            load = 1'b0;
            check($sformatf("digit%0d", k), digit_n, dig(k));
            check($sformatf("code%0d", k),
                  {selector, entry_Bit1, entry_Bit0}, code);
            check("fd_lit", frame_done, first && wrapped);
            first = 1'b0;
            if (i == ld_at) begin
                load     = 1'b1;
                codes_in = ld_val;
            end
        end
    endtask

    initial begin
        repeat (2) tick();
        check("rst_digit", digit_n, 4'b1111);
        check("rst_code", {selector, entry_Bit1, entry_Bit0}, 3'b000);
        check("rst_fd", frame_done, 1'b0);
        rst_n = 1'b1;

        // scan order
        codes_in = 12'o7531;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("idle_digit", digit_n, 4'b1111);
        en = 1'b1;
        run_digit(0, 3'o1, 1'b0, -1, 12'o0, DW);
        run_digit(1, 3'o3, 1'b0, -1, 12'o0, DW);
        run_digit(2, 3'o5, 1'b0, -1, 12'o0, DW);
        run_digit(3, 3'o7, 1'b0, -1, 12'o0, DW);

        // tear-free: load mid-frame, only the next frame sees it
        run_digit(0, 3'o1, 1'b1, -1, 12'o0, DW);
        run_digit(1, 3'o3, 1'b0, 1, 12'o0000, DW);
        run_digit(2, 3'o5, 1'b0, -1, 12'o0, DW);
        run_digit(3, 3'o7, 1'b0, -1, 12'o0, DW);
        run_digit(0, 3'o0, 1'b1, -1, 12'o0, DW);
        run_digit(1, 3'o0, 1'b0, -1, 12'o0, DW);
        run_digit(2, 3'o0, 1'b0, -1, 12'o0, DW);

        // load coinciding with the wrap edge goes straight to active
        run_digit(3, 3'o0, 1'b0, DW - 1, 12'o2222, DW);
        run_digit(0, 3'o2, 1'b1, -1, 12'o0, DW);
        run_digit(1, 3'o2, 1'b0, -1, 12'o0, DW);

        // en dropped while digit 2 lit
        run_digit(2, 3'o2, 1'b0, -1, 12'o0, 2);
        en = 1'b0;
        tick();
        check("en_off_digit", digit_n, 4'b1111);
        check("en_off_fd", frame_done, 1'b0);
        tick();
        check("en_off_hold", digit_n, 4'b1111);
        en = 1'b1;
        run_digit(0, 3'o2, 1'b0, -1, 12'o0, DW);
        run_digit(1, 3'o2, 1'b0, -1, 12'o0, DW);
        run_digit(2, 3'o2, 1'b0, -1, 12'o0, DW);
        run_digit(3, 3'o2, 1'b0, -1, 12'o0, DW);

        // asynchronous reset mid-SHOW, checked before any edge
        run_digit(0, 3'o2, 1'b1, -1, 12'o0, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_digit", digit_n, 4'b1111);
        check("arst_code", {selector, entry_Bit1, entry_Bit0}, 3'b000);
        check("arst_fd", frame_done, 1'b0);
        #2 rst_n = 1'b1;
        run_digit(0, 3'o0, 1'b0, -1, 12'o0, DW);
        run_digit(1, 3'o0, 1'b0, -1, 12'o0, DW);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
